// File: rtl/fifo_contention_tree_x4_if.sv
// Pixel aggregation bundle: four producer lanes in, one Z-buffer stream out,
// plus per-lane thermometer fill levels and non-empty requests.
interface fifo_contention_tree_x4_if #(
  parameter int MEM_LENGTH  = 8,
  parameter int PIXEL_WIDTH = 16
);
  logic [PIXEL_WIDTH-1:0] pix_in_1, pix_in_2, pix_in_3, pix_in_4;
  logic                   load_1, load_2, load_3, load_4;
  logic                   rdy_z_buffer;
  logic [PIXEL_WIDTH-1:0] pix_out;
  logic                   send_z_buffer;
  logic [MEM_LENGTH-1:0]  fill_1, fill_2, fill_3, fill_4;
  logic                   req_1, req_2, req_3, req_4;

  modport master (
    output pix_in_1, pix_in_2, pix_in_3, pix_in_4,
    output load_1, load_2, load_3, load_4, rdy_z_buffer,
    input  pix_out, send_z_buffer,
    input  fill_1, fill_2, fill_3, fill_4,
    input  req_1, req_2, req_3, req_4
  );

  modport slave (
    input  pix_in_1, pix_in_2, pix_in_3, pix_in_4,
    input  load_1, load_2, load_3, load_4, rdy_z_buffer,
    output pix_out, send_z_buffer,
    output fill_1, fill_2, fill_3, fill_4,
    output req_1, req_2, req_3, req_4
  );
endinterface

// File: rtl/fifo_contention_tree_x4.sv
// Four pixel FIFOs drained through a two-level arbitration tree into one stream.
// CT_ROUND_ROBIN_EN selects round-robin tree nodes; otherwise fixed priority 1>2>3>4.
module fifo_contention_tree_x4 #(
  parameter int MEM_LENGTH  = 8,
  parameter int PIXEL_WIDTH = 16
) (
  input logic                      clk,
  input logic                      reset,
  fifo_contention_tree_x4_if.slave bus
);
  localparam int PW = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1;
  localparam int CW = $clog2(MEM_LENGTH + 1);

  logic [PIXEL_WIDTH-1:0] mem [4][MEM_LENGTH];
  logic [PW-1:0]          wr_ptr [4];
  logic [PW-1:0]          rd_ptr [4];
  logic [CW-1:0]          occ [4];
  logic [PIXEL_WIDTH-1:0] pix_in [4];
  logic [MEM_LENGTH-1:0]  fill [4];
  logic [3:0]             load, req, full, wr_en, rd_en;
  logic [1:0]             win;
  logic                   pop;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic                   send_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MEM_LENGTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pix_in[0] = bus.pix_in_1;
  assign pix_in[1] = bus.pix_in_2;
  assign pix_in[2] = bus.pix_in_3;
  assign pix_in[3] = bus.pix_in_4;
  assign load      = {bus.load_4, bus.load_3, bus.load_2, bus.load_1};
  assign pop       = bus.rdy_z_buffer && (|req);

  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign req[n]   = (occ[n] != '0);
    assign full[n]  = (occ[n] == CW'(MEM_LENGTH));
    assign rd_en[n] = pop && (win == 2'(n));
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
    assign wr_en[n] = load[n] && (!full[n] || rd_en[n]);
    for (genvar i = 0; i < MEM_LENGTH; i++) begin : g_therm
      assign fill[n][i] = (occ[n] > CW'(i));
    end
  end

`ifdef CT_ROUND_ROBIN_EN
  // Each pointer set means "prefer the upper input" at that node.
  logic ptr_a, ptr_b, ptr_r;
  logic req_a, req_b, gnt_a_hi, gnt_b_hi, gnt_r_b;

  always_comb begin
    req_a    = req[0] | req[1];
    req_b    = req[2] | req[3];
    gnt_a_hi = req[1] & (~req[0] | ptr_a);
    gnt_b_hi = req[3] & (~req[2] | ptr_b);
    gnt_r_b  = req_b & (~req_a | ptr_r);
    win      = gnt_r_b ? {1'b1, gnt_b_hi} : {1'b0, gnt_a_hi};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_a <= 1'b0;
      ptr_b <= 1'b0;
      ptr_r <= 1'b0;
    end else if (pop) begin
      ptr_r <= ~gnt_r_b;
      if (gnt_r_b) ptr_b <= ~gnt_b_hi;
      else         ptr_a <= ~gnt_a_hi;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if      (req[0]) win = 2'd0;
    else if (req[1]) win = 2'd1;
    else if (req[2]) win = 2'd2;
    else if (req[3]) win = 2'd3;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        occ[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (wr_en[n]) wr_ptr[n] <= ptr_inc(wr_ptr[n]);
        if (rd_en[n]) rd_ptr[n] <= ptr_inc(rd_ptr[n]);
        case ({wr_en[n], rd_en[n]})
          2'b10:   occ[n] <= occ[n] + CW'(1);
          2'b01:   occ[n] <= occ[n] - CW'(1);
          default: occ[n] <= occ[n];
        endcase
      end
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (!reset && wr_en[n]) mem[n][wr_ptr[n]] <= pix_in[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      send_q <= 1'b0;
      pix_q  <= '0;
    end else begin
      send_q <= pop;
      if (pop) pix_q <= mem[win][rd_ptr[win]];
    end
  end

  assign bus.pix_out       = pix_q;
  assign bus.send_z_buffer = send_q;
  assign bus.fill_1        = fill[0];
  assign bus.fill_2        = fill[1];
  assign bus.fill_3        = fill[2];
  assign bus.fill_4        = fill[3];
  assign bus.req_1         = req[0];
  assign bus.req_2         = req[1];
  assign bus.req_3         = req[2];
  assign bus.req_4         = req[3];
endmodule

// File: tb/tb_fifo_contention_tree_x4.sv
// Self-checking bench for fifo_contention_tree_x4: table-driven fill/drain vectors
// plus a per-lane FIFO model feeding an expected-pixel scoreboard queue.
module tb_fifo_contention_tree_x4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_contention_tree_x4_if bus ();
  fifo_contention_tree_x4 dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rdy;
    logic [3:0]  load;
    logic [15:0] base;
    logic        chk_pix;
    logic [15:0] exp_pix;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] mbuf [4][8];
  int          mhead [4];
  int          mcnt [4];
  int          pa, pb, pr;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fill_of(input int n);
    case (n)
      0:       return bus.fill_1;
      1:       return bus.fill_2;
      2:       return bus.fill_3;
      default: return bus.fill_4;
    endcase
  endfunction

  function automatic logic req_of(input int n);
    case (n)
      0:       return bus.req_1;
      1:       return bus.req_2;
      2:       return bus.req_3;
      default: return bus.req_4;
    endcase
  endfunction

  function automatic logic [7:0] therm(input int cnt);
    logic [7:0] t = 8'h00;
    for (int i = 0; i < cnt; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic int pick();
`ifdef CT_ROUND_ROBIN_EN
    bit ra, rb;
    int side, lo, pref;
    ra   = (mcnt[0] > 0) || (mcnt[1] > 0);
    rb   = (mcnt[2] > 0) || (mcnt[3] > 0);
    side = (ra && rb) ? pr : (ra ? 0 : 1);
    lo   = side * 2;
    pref = side ? pb : pa;
    if (mcnt[lo] > 0 && mcnt[lo+1] > 0) return pref;
    return (mcnt[lo] > 0) ? lo : lo + 1;
`else
    for (int n = 0; n < 4; n++) if (mcnt[n] > 0) return n;
    return 0;
`endif
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 4; n++) begin
      mhead[n] = 0;
      mcnt[n]  = 0;
    end
    pa = 0; pb = 2; pr = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic rst, input logic [3:0] ld, input logic [15:0] base,
                      input logic rdy);
    int w;
    @(negedge clk);
    reset            = rst;
    bus.rdy_z_buffer = rdy;
    bus.load_1 = ld[0]; bus.load_2 = ld[1]; bus.load_3 = ld[2]; bus.load_4 = ld[3];
    bus.pix_in_1 = base + 16'd1; bus.pix_in_2 = base + 16'd2;
    bus.pix_in_3 = base + 16'd3; bus.pix_in_4 = base + 16'd4;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (rdy && (mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3]) > 0) begin
        w = pick();
        exp_q.push_back(mbuf[w][mhead[w]]);
        mhead[w] = (mhead[w] + 1) % 8;
        mcnt[w]--;
        pr = (w < 2) ? 1 : 0;
        if (w < 2) pa = (w == 0) ? 1 : 0;
        else       pb = (w == 2) ? 3 : 2;
      end
      for (int n = 0; n < 4; n++) begin
        if (ld[n] && mcnt[n] < 8) begin
          mbuf[n][(mhead[n] + mcnt[n]) % 8] = base + 16'(n + 1);
          mcnt[n]++;
        end
      end
    end
    #1;
    chk("send_z_buffer", {31'b0, bus.send_z_buffer}, {31'b0, exp_q.size() > 0});
    if (bus.send_z_buffer && exp_q.size() > 0)
      chk("pix_out_scoreboard", {16'b0, bus.pix_out}, {16'b0, exp_q.pop_front()});
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("fill_%0d", n + 1), {24'b0, fill_of(n)}, {24'b0, therm(mcnt[n])});
      chk($sformatf("req_%0d", n + 1), {31'b0, req_of(n)}, {31'b0, mcnt[n] > 0});
    end
  endtask

  vec_t tab [15];

  initial begin
    reset = 1'b1;
    bus.rdy_z_buffer = 1'b0;
    bus.load_1 = 1'b0; bus.load_2 = 1'b0; bus.load_3 = 1'b0; bus.load_4 = 1'b0;
    bus.pix_in_1 = '0; bus.pix_in_2 = '0; bus.pix_in_3 = '0; bus.pix_in_4 = '0;
    model_clear();

    tab[0] = '{1'b0, 4'hF, 16'h0000, 1'b0, 16'h0};
    tab[1] = '{1'b0, 4'hF, 16'h0004, 1'b0, 16'h0};
    tab[2] = '{1'b0, 4'hF, 16'h0008, 1'b0, 16'h0};
    begin
`ifdef CT_ROUND_ROBIN_EN
      logic [15:0] order [12] = '{16'h1, 16'h3, 16'h2, 16'h4, 16'h5, 16'h7,
                                  16'h6, 16'h8, 16'h9, 16'hB, 16'hA, 16'hC};
`else
      logic [15:0] order [12] = '{16'h1, 16'h5, 16'h9, 16'h2, 16'h6, 16'hA,
                                  16'h3, 16'h7, 16'hB, 16'h4, 16'h8, 16'hC};
`endif
      for (int i = 0; i < 12; i++) tab[3 + i] = '{1'b1, 4'h0, 16'h0, 1'b1, order[i]};
    end

    // Reset then idle
    step(1'b1, 4'h0, 16'h0, 1'b0);
    step(1'b1, 4'h0, 16'h0, 1'b0);
    step(1'b0, 4'h0, 16'h0, 1'b0);
    chk("reset_pix_out", {16'b0, bus.pix_out}, 32'h0);

    // Fill all four lanes to three entries, then drain through the tree
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tab[i].load, tab[i].base, tab[i].rdy);
      if (i == 2)
        chk("fill_1_three", {24'b0, bus.fill_1}, 32'h07);
      if (tab[i].chk_pix) begin
        chk($sformatf("drain_send_%0d", i - 3), {31'b0, bus.send_z_buffer}, 32'h1);
        chk($sformatf("drain_pix_%0d", i - 3), {16'b0, bus.pix_out}, {16'b0, tab[i].exp_pix});
      end
    end
    step(1'b0, 4'h0, 16'h0, 1'b1);

    // Overflow FIFO 1: ninth word dropped
    for (int k = 0; k < 9; k++) step(1'b0, 4'b0001, 16'h0100 + 16'(k), 1'b0);
    chk("fill_1_full", {24'b0, bus.fill_1}, 32'hFF);
    for (int k = 0; k < 9; k++) step(1'b0, 4'h0, 16'h0, 1'b1);

    // FIFO 2 full, simultaneous pop and write keeps it full
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0010, 16'h0200 + 16'(k), 1'b0);
    step(1'b0, 4'b0010, 16'h0210, 1'b1);
    chk("fill_2_pop_load", {24'b0, bus.fill_2}, 32'hFF);
    for (int k = 0; k < 9; k++) step(1'b0, 4'h0, 16'h0, 1'b1);

    // Mid-operation reset with load and ready active in the reset cycle
    step(1'b0, 4'hF, 16'h0300, 1'b0);
    step(1'b0, 4'hF, 16'h0310, 1'b0);
    step(1'b1, 4'hF, 16'h0320, 1'b1);
    chk("midreset_pix_out", {16'b0, bus.pix_out}, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 16'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_contention_tree_x4.md
# fifo_contention_tree_x4

Four-input pixel aggregation stage: four independent pixel FIFOs, each written by its own producer, drained through a two-level contention (arbitration) tree into a single pixel stream toward the Z-buffer. It sits between the four rasterizer lanes and the Z-buffer input port. Each FIFO exposes a thermometer fill level so upstream producers can throttle themselves.

## Interface
- MEM_LENGTH, 8: depth of each FIFO in entries; also the width of each fill vector.
- PIXEL_WIDTH, 16: pixel word width.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_in_1..pix_in_4  in  PIXEL_WIDTH  write data for FIFO n.
- load_1..load_4  in  1  write strobe for FIFO n; one entry per cycle while high.
- rdy_z_buffer  in  1  Z-buffer can accept a pixel this cycle.
- pix_out  out  PIXEL_WIDTH  pixel delivered to the Z-buffer, registered.
- send_z_buffer  out  1  pix_out valid strobe, one cycle per pixel.
- fill_1..fill_4  out  MEM_LENGTH  thermometer occupancy of FIFO n: bit i = 1 iff occupancy > i.
- req_1..req_4  out  1  FIFO n non-empty (request into the tree).

## Operation
- FIFO n: circular buffer, MEM_LENGTH entries, read/write pointers wrap modulo MEM_LENGTH, occupancy counter 0..MEM_LENGTH.
- Write: load_n=1 and FIFO not full → store pix_in_n, occupancy+1. load_n=1 while full → write dropped, no state change.
- req_n = (occupancy_n != 0), combinational from state.
- Tree: leaf node A arbitrates req_1/req_2, leaf B arbitrates req_3/req_4, root arbitrates A/B. Node requests = OR of its inputs.
- Pop: rdy_z_buffer=1 and any req → exactly one FIFO (tree winner) popped; its head word loaded into pix_out, send_z_buffer=1 next cycle. Otherwise send_z_buffer=0, pix_out holds its last value.
- Simultaneous load and pop on the same FIFO: both performed, occupancy unchanged; legal even when full (the pop frees the slot).
- A pop on an empty FIFO cannot occur (winner is always a requesting FIFO).
- Reset: all FIFOs emptied (contents discarded, pointers 0), fill_n=0, req_n=0, pix_out=0, send_z_buffer=0, arbitration pointers to reset state. Applies equally mid-operation; a load or pop in the reset cycle is ignored.

## Timing
- Write at edge t → fill_n and req_n reflect it after edge t.
- Write-to-output minimum latency: 2 cycles (written at edge t, popped at edge t+1, pix_out/send valid after edge t+1).
- Pop decision uses req and rdy_z_buffer sampled at edge t; pix_out/send_z_buffer valid after edge t, fill_n decrements after the same edge.
- Sustained throughput: one pixel per cycle while rdy_z_buffer=1 and any FIFO non-empty.
- Order within one FIFO is strict FIFO.

## Configuration
- CT_ROUND_ROBIN_EN defined: each tree node holds a 1-bit pointer; reset prefers lower input (1 at A, 3 at B, A at root); when a node passes a grant, its pointer flips to the other input. Only nodes on the granted path update. All four full → grant order 1,3,2,4,1,3,...
- CT_ROUND_ROBIN_EN undefined: fixed priority 1 > 2 > 3 > 4, no pointer state.

## Test plan
- Reset then idle: fill_n=0, req_n=0, send_z_buffer=0, pix_out=0.
- rdy_z_buffer=0; load 0x0001..0x0004, then 0x0005..0x0008, then 0x0009..0x000C on FIFOs 1..4 → each fill_n=8'b0000_0111, all req_n=1, send_z_buffer never asserted.
- Continuing, raise rdy_z_buffer → with CT_ROUND_ROBIN_EN output 0x1,0x3,0x2,0x4,0x5,0x7,0x6,0x8,0x9,0xB,0xA,0xC on 12 consecutive cycles; without: 0x1,0x5,0x9,0x2,0x6,0xA,0x3,...; then send_z_buffer=0, all fill=0.
- Write 9 words into FIFO 1 with rdy_z_buffer=0 → fill_1=8'hFF, 9th word dropped; drain yields words 1..8 only.
- FIFO 2 full, load_2 and rdy_z_buffer=1 with only req_2 active → one pop and one write same cycle, fill_2 stays 8'hFF.
- Assert reset with all FIFOs partly full → next cycle all fill/req/send=0; subsequent drain produces nothing.
